iiitb_fifo_uart_tx: RTL



---
 rtl/iiitb_fifo_uart_tx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/iiitb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// iiitb_fifo_uart_tx
//   Read-side consumer of an 8-bit FIFO. Pops one byte at a time and sends it
//   as an asynchronous serial frame: start bit, 8 data bits LSB first, no
//   parity, then STOP_BITS stop bits. This block is the only reader of its
//   FIFO and only pops after seeing the FIFO non-empty while idle.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-low reset
//   tx_en        transmit enable, only looked at while idle
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO read data, valid the cycle after the pop edge
//   fifo_rd_en   one-cycle pop pulse
//   tx           serial line, idle high
//   tx_busy      high whenever a frame is in progress (state != IDLE)
//   frame_count  completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module iiitb_fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        tx_busy,
  output logic [15:0] frame_count
);

  // Sized for the longest hold (two stop bits) so it never overflows.
  localparam int CNT_W = $clog2(2 * CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [15:0]      count_q, count_d;

  logic bit_done_s;
  logic stop_done_s;

  assign bit_done_s  = (cnt_q == BIT_LAST);
  assign stop_done_s = (cnt_q == STOP_LAST);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // Entering POP only on a non-empty flag makes underflow impossible.
        if (tx_en && !fifo_empty) begin
          state_d = S_POP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP:  state_d = S_LOAD;
      S_LOAD: state_d = S_START;
      S_START: begin
        if (bit_done_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_done_s && (bit_q == 3'd7)) begin
          state_d = S_STOP;
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (stop_done_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the cycle counter, bit index, shift register and frame count.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    count_d = count_q;
    case (state_q)
      S_LOAD: begin
        // FIFO read data arrives one cycle after the pop pulse.
        shift_d = fifo_data;
        cnt_d   = CNT_ZERO;
        bit_d   = 3'd0;
      end
      S_START: begin
        if (bit_done_s) begin
          cnt_d = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_done_s) begin
          cnt_d   = CNT_ZERO;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (stop_done_s) begin
          cnt_d   = CNT_ZERO;
          count_d = count_q + 16'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d = CNT_ZERO;
      end
    endcase
  end

  // Outputs decoded purely from registered state, no input-to-output path.
  always_comb begin
    fifo_rd_en = 1'b0;
    tx         = 1'b1;
    tx_busy    = 1'b1;
    case (state_q)
      S_IDLE:  tx_busy    = 1'b0;
      S_POP:   fifo_rd_en = 1'b1;
      S_LOAD:  tx         = 1'b1;
      S_START: tx         = 1'b0;
      S_DATA:  tx         = shift_q[0];
      S_STOP:  tx         = 1'b1;
      default: tx_busy    = 1'b0;
    endcase
  end

  assign frame_count = count_q;

endmodule
